// File: rtl/deserializer_framed.sv
// Framed serial-to-parallel deserializer.
// A start pulse accepted in IDLE optionally waits SKIP_CYCLES lead-in clocks.
// It then captures WORD_COUNT words of WORD_SIZE bits, one bit per clock.
// Each completed word lands in a valid/ready holding register. Overwriting an
// unconsumed word raises a sticky overrun flag.
module deserializer_framed #(
    parameter int WORD_SIZE   = 8,
    parameter int WORD_COUNT  = 2,
    parameter int MSB_FIRST   = 1,
    parameter int SKIP_CYCLES = 1,
    localparam int IDX_W      = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 data_in,
    input  logic                 data_ready,
    output logic [WORD_SIZE-1:0] data_out,
    output logic                 data_valid,
    output logic [IDX_W-1:0]     word_index,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 overrun
);

    localparam int BIT_W  = $clog2(WORD_SIZE);
    localparam int SKIP_W = (SKIP_CYCLES > 1) ? $clog2(SKIP_CYCLES) : 1;

    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_SIZE - 1);
    localparam logic [IDX_W-1:0]  WORD_LAST = IDX_W'(WORD_COUNT - 1);
    localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'((SKIP_CYCLES > 0) ? (SKIP_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SKIP    = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    state_t                r_state;
    logic [WORD_SIZE-1:0]  r_shift;
    logic [BIT_W-1:0]      r_bit_cnt;
    logic [IDX_W-1:0]      r_word_cnt;
    logic [SKIP_W-1:0]     r_skip_cnt;
    logic                  r_busy;
    logic                  r_frame_done;
    logic [WORD_SIZE-1:0]  r_data_out;
    logic                  r_data_valid;
    logic [IDX_W-1:0]      r_word_index;
    logic                  r_overrun;

    logic [WORD_SIZE-1:0]  w_shift_msb;
    logic [WORD_SIZE-1:0]  w_shift_lsb;
    logic [WORD_SIZE-1:0]  w_shift_next;
    logic                  w_accept;
    logic                  w_word_end;

    // MSB-first pushes new bits in at bit 0 and moves earlier bits up.
    // LSB-first pushes them in at the top, so the first bit ends in bit 0.
    assign w_shift_msb  = {r_shift[WORD_SIZE-2:0], data_in};
    assign w_shift_lsb  = {data_in, r_shift[WORD_SIZE-1:1]};
    assign w_shift_next = (MSB_FIRST != 0) ? w_shift_msb : w_shift_lsb;

    assign w_accept   = (r_state == ST_IDLE) && start;
    assign w_word_end = (r_state == ST_CAPTURE) && (r_bit_cnt == BIT_LAST);

    // Frame sequencer: lead-in skip, bit/word counting, busy and frame_done.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_word_cnt   <= '0;
            r_skip_cnt   <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_bit_cnt  <= '0;
                        r_word_cnt <= '0;
                        r_skip_cnt <= '0;
                        r_busy     <= 1'b1;
                        if (SKIP_CYCLES > 0) begin
                            r_state <= ST_SKIP;
                        end else begin
                            r_state <= ST_CAPTURE;
                        end
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                ST_SKIP: begin
                    if (r_skip_cnt == SKIP_LAST) begin
                        r_skip_cnt <= '0;
                        r_state    <= ST_CAPTURE;
                    end else begin
                        r_skip_cnt <= r_skip_cnt + 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    r_shift <= w_shift_next;
                    if (r_bit_cnt == BIT_LAST) begin
                        r_bit_cnt <= '0;
                        if (r_word_cnt == WORD_LAST) begin
                            r_word_cnt   <= '0;
                            r_state      <= ST_IDLE;
                            r_busy       <= 1'b0;
                            r_frame_done <= 1'b1;
                        end else begin
                            r_word_cnt <= r_word_cnt + 1'b1;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Output holding register: a load beats a consume, and overwriting an unconsumed word sets overrun.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_word_index <= '0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_overrun <= 1'b0;
            end else if (w_word_end && r_data_valid && !data_ready) begin
                r_overrun <= 1'b1;
            end else begin
                r_overrun <= r_overrun;
            end

            if (w_word_end) begin
                r_data_out   <= w_shift_next;
                r_word_index <= r_word_cnt;
                r_data_valid <= 1'b1;
            end else if (r_data_valid && data_ready) begin
                r_data_valid <= 1'b0;
            end else begin
                r_data_valid <= r_data_valid;
            end
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign word_index = r_word_index;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign overrun    = r_overrun;

endmodule

// File: doc/deserializer_framed.md
Name: deserializer_framed

Overview:
- Parametrised successor to the start-triggered serial-to-parallel deserializer with word counter.
- One `start` pulse captures a frame of WORD_COUNT words of WORD_SIZE bits each from `data_in`, one bit per clock.
- Adds selectable bit order, a configurable lead-in skip, and a valid/ready output holding register with overrun detection.
- Sits between a serial receive pin/synchroniser and a parallel consumer (FIFO or register file).

Parameters:
- WORD_SIZE, 8: bits per word; must be at least 2.
- WORD_COUNT, 2: words per frame; must be at least 1.
- MSB_FIRST, 1: 1 means the first received bit of a word is bit WORD_SIZE-1; 0 means the first received bit is bit 0.
- SKIP_CYCLES, 1: clock cycles discarded between start acceptance and the first sampled bit; 0 is allowed.
- Local parameter IDX_W = max(1, clog2(WORD_COUNT)).

Ports:
- clock, in, 1: single clock; all state updates on its rising edge.
- reset, in, 1: asynchronous, active-low reset. It takes effect immediately when low; release is synchronous to the design.
- start, in, 1: frame request; sampled only in IDLE.
- data_in, in, 1: serial data, sampled on rising edges in CAPTURE.
- data_ready, in, 1: consumer accepts `data_out` when high together with `data_valid`.
- data_out, out, WORD_SIZE: holding register containing the last completed word.
- data_valid, out, 1: holding register contains an unconsumed word.
- word_index, out, IDX_W: frame position (0-based) of the word in `data_out`.
- busy, out, 1: high in SKIP or CAPTURE.
- frame_done, out, 1: one-cycle pulse after the final bit of the frame is captured.
- overrun, out, 1: sticky; an unconsumed word was overwritten.

Behaviour:
- Reset values (while `reset` is low): state IDLE; `data_out`=0; `data_valid`=0; `word_index`=0; `busy`=0; `frame_done`=0; `overrun`=0; shift register and counters 0. Reset mid-frame aborts the frame with no partial word output.
- State IDLE:
  - `start`=1 at edge E0 moves to SKIP if SKIP_CYCLES>0, otherwise to CAPTURE.
  - On acceptance: `overrun` clears; bit and word counters clear.
- State SKIP:
  - Counts SKIP_CYCLES edges, ignoring `data_in`, then moves to CAPTURE.
- State CAPTURE:
  - Each edge samples `data_in` into the shift register. MSB_FIRST=1 shifts toward the MSB; MSB_FIRST=0 shifts toward the LSB, so the first bit ends in bit 0.
  - The bit counter runs 0..WORD_SIZE-1.
- Word completion, on the edge sampling bit WORD_SIZE-1:
  - The complete word, including that bit, loads `data_out`.
  - `word_index` takes the current word count.
  - `data_valid` goes to 1.
  - The bit counter wraps to 0 and the word counter increments.
- Frame completion, when the completed word is word WORD_COUNT-1:
  - Next state is IDLE; `busy` falls after that edge.
  - `frame_done` is 1 for exactly the following cycle.
  - The word counter wraps to 0.
- Latency: with SKIP_CYCLES=S, word k becomes valid after edge E0+S+(k+1)*WORD_SIZE.
- Handshake:
  - `data_valid` falls after an edge with `data_valid`=1, `data_ready`=1 and no load.
  - `data_out` is stable while `data_valid`=1 except when a new word loads.
- Simultaneous load and consume: the load wins; `data_valid` stays 1 and `overrun` is not set.
- Load while `data_valid`=1 and `data_ready`=0: the new word overwrites `data_out` and `overrun` sets. `overrun` holds until the next accepted `start` or reset.
- `start` is ignored while `busy`=1.
- A new `start` is accepted at the first edge in IDLE, i.e. the cycle `frame_done` is high.

Test Plan:
- Base case. Setup: WORD_SIZE=8, WORD_COUNT=2, MSB_FIRST=1, SKIP_CYCLES=1, `data_ready`=1. Stimulus: `start` pulse, one skip bit, then bits 0,1,0,1,0,0,0,1 and 1,0,1,1,0,0,0,1. Required: `data_out`=0x51 with `word_index`=0 valid after E9; then 0xB1 with `word_index`=1 after E17; `frame_done` pulse in the cycle after E17; `busy` low from the cycle after E17; `overrun`=0.
- LSB-first: same stream with MSB_FIRST=0. Required: 0x8A then 0x8D, same timing.
- Overrun: same stream with `data_ready`=0 throughout. Required: `data_out`=0xB1 and `data_valid`=1 at frame end; `overrun`=1 after E17. The next `start` clears `overrun`.
- Handshake: `data_ready` low until 3 cycles after word 0 loads, then high. Required: 0x51 held stable with `data_valid`=1 until the accepting edge. `data_valid` falls after the accepting edge and rises again after E17.
- Start while busy: `start` pulses at E5 and E12 during a frame. Required: no restart; words and timing identical to the base case. A `start` during the `frame_done` cycle begins a new frame.
- Reset mid-frame: `reset` low at E6 (mid word 0). Required: all outputs 0 immediately and no word is emitted. After release, a fresh frame captures 0x51 and 0xB1 normally.
